// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, req/ready handshake to
// instruction memory, decode back-pressure, branch redirect and fetch-timeout pulse.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                    MAX_WAIT   = 15
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  output logic                  IMemReq,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  input  logic                  IMemReady,
  input  logic [31:0]           IMemRData,
  input  logic                  Stall,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCBranch,
  output logic [31:0]           Instr,
  output logic [5:0]            Op,
  output logic [5:0]            Funct,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  output logic                  InstrValid,
  output logic                  FetchErr
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
  logic [31:0]             instr_r, instr_s;
  logic [ADDR_WIDTH-1:0]   pcplus4_r, pcplus4_s;
  logic                    valid_r, valid_s;
  logic [CW-1:0]           wait_r, wait_s;

  logic                    req_s;
  logic                    accept_s;
  logic                    timeout_s;
  logic                    hold_s;
  logic [ADDR_WIDTH-1:0]   pc_inc_s;
  logic [ADDR_WIDTH-1:0]   target_s;
  logic                    unused_branch_lsb_s;

  // The low two target bits are dropped: instructions are word aligned.
  assign unused_branch_lsb_s = ^PCBranch[1:0];
  assign target_s            = {PCBranch[ADDR_WIDTH-1:2], 2'b00};
  assign pc_inc_s            = pc_r + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};

  // Handshake qualifiers: a full IF/ID slot under Stall blocks new requests.
  always_comb begin
    hold_s    = valid_r && Stall;
    req_s     = 1'b0;
    accept_s  = 1'b0;
    timeout_s = 1'b0;
    if (state_r == ST_FETCH) begin
      req_s     = !hold_s;
      accept_s  = req_s && IMemReady && !PCSrc;
      timeout_s = req_s && !IMemReady && !PCSrc && (wait_r == CW'(MAX_WAIT - 1));
    end else begin
      req_s     = 1'b0;
    end
  end

  // Next-state for FSM, PC, IF/ID register and wait counter; redirect wins over all.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    instr_s   = instr_r;
    pcplus4_s = pcplus4_r;
    valid_s   = valid_r;
    wait_s    = wait_r;

    case (state_r)
      ST_IDLE:  state_s = ST_FETCH;
      ST_FETCH: state_s = ST_FETCH;
      default:  state_s = ST_IDLE;
    endcase

    if (PCSrc) begin
      pc_s    = target_s;
      valid_s = 1'b0;
    end else if (accept_s) begin
      pc_s      = pc_inc_s;
      instr_s   = IMemRData;
      pcplus4_s = pc_inc_s;
      valid_s   = 1'b1;
    end else if (!hold_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    // A timeout retries the same PC with a fresh count.
    if (PCSrc || !req_s || IMemReady) begin
      wait_s = {CW{1'b0}};
    end else if (timeout_s) begin
      wait_s = {CW{1'b0}};
    end else begin
      wait_s = wait_r + CW'(1);
    end
  end

  // State and pipeline registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      pcplus4_r <= {ADDR_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      wait_r    <= {CW{1'b0}};
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      pcplus4_r <= pcplus4_s;
      valid_r   <= valid_s;
      wait_r    <= wait_s;
    end
  end

  assign IMemReq    = req_s;
  assign IMemAddr   = pc_r;
  assign Instr      = instr_r;
  assign Op         = instr_r[31:26];
  assign Funct      = instr_r[5:0];
  assign PCPlus4    = pcplus4_r;
  assign InstrValid = valid_r;
  assign FetchErr   = timeout_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the steady pipeline plus hand-written
// sequences for reset, timeout, wrap-around and asynchronous reset under stall.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b1;
  logic        IMemReq, IMemReady, Stall, PCSrc, InstrValid, FetchErr;
  logic [31:0] IMemAddr, IMemRData, PCBranch, Instr, PCPlus4;
  logic [5:0]  Op, Funct;

  logic        req2, valid2, err2;
  logic [31:0] addr2, rdata2, instr2, pcp4_2;
  logic [5:0]  op2, funct2;
  logic        ready2 = 1'b1, stall2 = 1'b0, pcsrc2 = 1'b0;
  logic [31:0] branch2 = 32'h0000_0000;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(15)) u_dut (
    .Clk(Clk), .ResetN(ResetN), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemRData(IMemRData), .Stall(Stall), .PCSrc(PCSrc),
    .PCBranch(PCBranch), .Instr(Instr), .Op(Op), .Funct(Funct), .PCPlus4(PCPlus4),
    .InstrValid(InstrValid), .FetchErr(FetchErr)
  );

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) u_wrap (
    .Clk(Clk), .ResetN(ResetN), .IMemReq(req2), .IMemAddr(addr2),
    .IMemReady(ready2), .IMemRData(rdata2), .Stall(stall2), .PCSrc(pcsrc2),
    .PCBranch(branch2), .Instr(instr2), .Op(op2), .Funct(funct2), .PCPlus4(pcp4_2),
    .InstrValid(valid2), .FetchErr(err2)
  );

  // Address-tagged memory word: Op = ~addr[7:2], low 26 bits = addr[25:0].
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[7:2], a[25:0]};
  endfunction

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic        ready;
    logic [31:0] branch;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcp4;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle of inputs, check request/error before the edge, then advance.
  task automatic step(input string nm, input logic st, input logic pc, input logic rdy,
                      input logic [31:0] br, input logic exp_req, input logic exp_err);
    Stall     = st;
    PCSrc     = pc;
    IMemReady = rdy;
    PCBranch  = br;
    IMemRData = word_at(IMemAddr);
    rdata2    = word_at(addr2);
    #1;
    chk({nm, ".req"}, {31'd0, IMemReq}, {31'd0, exp_req});
    chk({nm, ".err"}, {31'd0, FetchErr}, {31'd0, exp_err});
    @(posedge Clk);
    #1;
  endtask

  task automatic post(input string nm, input logic [31:0] addr, input logic valid,
                      input logic [31:0] instr, input logic [31:0] pcp4);
    logic [31:0] ei;
    ei = instr;
    chk({nm, ".addr"}, IMemAddr, addr);
    chk({nm, ".valid"}, {31'd0, InstrValid}, {31'd0, valid});
    chk({nm, ".instr"}, Instr, instr);
    chk({nm, ".op"}, {26'd0, Op}, {26'd0, ei[31:26]});
    chk({nm, ".funct"}, {26'd0, Funct}, {26'd0, ei[5:0]});
    chk({nm, ".pcp4"}, PCPlus4, pcp4);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h08, 1'b1, word_at(32'h04), 32'h08};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0C, 1'b1, word_at(32'h08), 32'h0C};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0C, 1'b1, word_at(32'h08), 32'h0C};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0C, 1'b1, word_at(32'h08), 32'h0C};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0C, 1'b1, word_at(32'h08), 32'h0C};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 1'b1, word_at(32'h0C), 32'h10};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h43, 1'b1, 32'h40, 1'b0, word_at(32'h0C), 32'h10};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h44, 1'b1, word_at(32'h40), 32'h44};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h80, 1'b0, word_at(32'h40), 32'h44};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h84, 1'b1, word_at(32'h80), 32'h84};

    Stall = 1'b0; PCSrc = 1'b0; IMemReady = 1'b1; PCBranch = 32'h0;
    IMemRData = 32'h0; rdata2 = 32'h0;
    #1 ResetN = 1'b0;
    #1;
    chk("rst.req", {31'd0, IMemReq}, 32'd0);
    chk("rst.err", {31'd0, FetchErr}, 32'd0);
    post("rst", 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst.wrap_addr", addr2, 32'hFFFF_FFFC);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    post("rst_held", 32'h0, 1'b0, 32'h0, 32'h0);
    ResetN = 1'b1;

    // IDLE for one cycle, then back-to-back fetches.
    step("idle", 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    post("idle", 32'h0, 1'b0, 32'h0, 32'h0);
    chk("wrap.idle_addr", addr2, 32'hFFFF_FFFC);
    step("f0", 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    post("f0", 32'h4, 1'b1, word_at(32'h0), 32'h4);
    chk("wrap.valid", {31'd0, valid2}, 32'd1);
    chk("wrap.pcp4", pcp4_2, 32'h0);
    chk("wrap.addr", addr2, 32'h0);
    chk("wrap.instr", instr2, 32'h03FF_FFFC);

    for (int i = 0; i < 10; i++) begin
      step($sformatf("v%0d", i), tbl[i].stall, tbl[i].pcsrc, tbl[i].ready,
           tbl[i].branch, tbl[i].exp_req, 1'b0);
      post($sformatf("v%0d", i), tbl[i].exp_addr, tbl[i].exp_valid,
           tbl[i].exp_instr, tbl[i].exp_pcp4);
    end

    // Memory silent for 20 cycles: one FetchErr on the 15th, PC held.
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("to%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, (i == 15));
      chk($sformatf("to%0d.addr", i), IMemAddr, 32'h84);
      chk($sformatf("to%0d.valid", i), {31'd0, InstrValid}, 32'd0);
    end
    step("to_ready", 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    post("to_ready", 32'h88, 1'b1, word_at(32'h84), 32'h88);

    // Asynchronous reset while stalled on a valid instruction.
    step("st", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    post("st", 32'h88, 1'b1, word_at(32'h84), 32'h88);
    #3 ResetN = 1'b0;
    #1;
    chk("arst.req", {31'd0, IMemReq}, 32'd0);
    chk("arst.err", {31'd0, FetchErr}, 32'd0);
    post("arst", 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge Clk);
    #1;
    chk("arst_hold.valid", {31'd0, InstrValid}, 32'd0);
    chk("arst_hold.addr", IMemAddr, 32'h0);
    ResetN = 1'b1;
    step("re_idle", 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    post("re_idle", 32'h0, 1'b0, 32'h0, 32'h0);
    step("re_f0", 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    post("re_f0", 32'h4, 1'b1, word_at(32'h0), 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
